piece_sequencer: RTL and testbench

//  Sequences the 7-piece random bag generator and feeds the game core one piece at a time.

---
 rtl/piece_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_piece_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/piece_sequencer.sv
// piece_sequencer: bag-fetch FSM feeding a circular piece FIFO,
// with head piece, pop handshake and 3-deep preview outputs.
module piece_sequencer #(
  parameter int DEPTH          = 14,
  parameter int REFILL_LEVEL   = 7,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  output logic        bag_newbag,
  input  logic        bag_ready,
  input  logic [20:0] bag_pieces,
  input  logic        flush,
  input  logic        piece_pop,
  output logic [2:0]  piece,
  output logic        piece_valid,
  output logic [8:0]  preview,
  output logic [1:0]  preview_count,
  output logic [3:0]  fill_level,
  output logic        bag_error
);

  localparam logic [3:0] LAST    = 4'(DEPTH - 1);
  localparam logic [3:0] FULL    = 4'(DEPTH);
  localparam logic [3:0] REFILL  = 4'(REFILL_LEVEL);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_LO,
    WAIT_HI,
    LOAD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  mem [DEPTH];
  logic [3:0]  head;
  logic [3:0]  tail;
  logic [3:0]  count;
  logic [20:0] shadow;
  logic [2:0]  idx;
  logic [9:0]  tcnt;
  logic        err;

  logic        cap;
  logic        ld;
  logic        tclr;
  logic        tinc;
  logic        err_set;
  logic        wr_en;
  logic        pop_en;
  logic [2:0]  ld_piece;
  logic [3:0]  p1;
  logic [3:0]  p2;
  logic [3:0]  p3;

  function automatic logic [3:0] nxt(input logic [3:0] p);
    return (p == LAST) ? 4'd0 : p + 4'd1;
  endfunction

  always_comb ld_piece = 3'(shadow >> (5'(idx) * 5'd3));

  // code 7 marks an unused bag slot and is never written
  assign wr_en  = ld && (ld_piece != 3'b111) && (count != FULL) && !flush;
  assign pop_en = piece_pop && piece_valid && !flush;

  always_comb begin
    state_n    = state;
    bag_newbag = 1'b0;
    cap        = 1'b0;
    ld         = 1'b0;
    tclr       = 1'b0;
    tinc       = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (count <= REFILL && !err && !flush)
          state_n = REQ;
      end
      REQ: begin
        bag_newbag = 1'b1;
        tclr       = 1'b1;
        state_n    = WAIT_LO;
      end
      WAIT_LO: begin
        if (tcnt == TO_LAST) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          tinc = 1'b1;
          if (!bag_ready)
            state_n = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bag_ready) begin
          cap     = 1'b1;
          state_n = LOAD;
        end else if (tcnt == TO_LAST) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          tinc = 1'b1;
        end
      end
      LOAD: begin
        ld = 1'b1;
        if (idx == 3'd6)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush)
      state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= 4'd0;
      tail   <= 4'd0;
      count  <= 4'd0;
      shadow <= 21'd0;
      idx    <= 3'd0;
      tcnt   <= 10'd0;
      err    <= 1'b0;
    end else if (flush) begin
      head   <= 4'd0;
      tail   <= 4'd0;
      count  <= 4'd0;
      shadow <= 21'd0;
      idx    <= 3'd0;
      tcnt   <= 10'd0;
      err    <= 1'b0;
    end else begin
      if (cap) begin
        shadow <= bag_pieces;
        idx    <= 3'd0;
      end else if (ld) begin
        idx <= idx + 3'd1;
      end
      if (tclr)
        tcnt <= 10'd0;
      else if (tinc)
        tcnt <= tcnt + 10'd1;
      if (err_set)
        err <= 1'b1;
      if (wr_en)
        tail <= nxt(tail);
      if (pop_en)
        head <= nxt(head);
      unique case ({wr_en, pop_en})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[tail] <= ld_piece;
  end

  assign p1 = nxt(head);
  assign p2 = nxt(p1);
  assign p3 = nxt(p2);

  assign piece_valid = (count != 4'd0);
  assign piece       = piece_valid ? mem[head] : 3'd0;
  assign fill_level  = count;
  assign bag_error   = err;

  always_comb begin
    preview       = 9'd0;
    preview_count = 2'd0;
    if (count >= 4'd2)
      preview[2:0] = mem[p1];
    if (count >= 4'd3)
      preview[5:3] = mem[p2];
    if (count >= 4'd4)
      preview[8:6] = mem[p3];
    if (count >= 4'd4)
      preview_count = 2'd3;
    else if (count != 4'd0)
      preview_count = 2'(count - 4'd1);
  end

endmodule

// File: tb/tb_piece_sequencer.sv
// tb_piece_sequencer: random pops/flush/reset against a queue-based
// model of the piece stream and bag handshake timing.
module tb_piece_sequencer;

  localparam int DEPTH  = 14;
  localparam int REFILL = 7;
  localparam int TO     = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        bag_newbag;
  logic        bag_ready;
  logic [20:0] bag_pieces;
  logic        flush;
  logic        piece_pop;
  logic [2:0]  piece;
  logic        piece_valid;
  logic [8:0]  preview;
  logic [1:0]  preview_count;
  logic [3:0]  fill_level;
  logic        bag_error;

  piece_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .bag_newbag    (bag_newbag),
    .bag_ready     (bag_ready),
    .bag_pieces    (bag_pieces),
    .flush         (flush),
    .piece_pop     (piece_pop),
    .piece         (piece),
    .piece_valid   (piece_valid),
    .preview       (preview),
    .preview_count (preview_count),
    .fill_level    (fill_level),
    .bag_error     (bag_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: piece queue plus fetch progress
  int   q[$];
  int   pend[$];
  bit   m_err;
  bit   m_wait;
  bit   m_low;
  int   m_wcnt;
  bit   exp_nb;

  // bag generator behaviour
  bit          g_on;
  bit          g_stuck;
  int          g_stale;
  int          g_low;
  logic [20:0] g_next;
  logic [20:0] forced[$];

  function automatic logic [20:0] rand_bag();
    logic [20:0] b = '0;
    for (int k = 0; k < 7; k++)
      b[3*k +: 3] = 3'($urandom_range(0, 7));
    return b;
  endfunction

  task automatic compare();
    int sz = q.size();
    logic [8:0] pv = '0;
    int pc;
    for (int i = 1; i <= 3; i++)
      if (sz > i) pv[3*(i-1) +: 3] = 3'(q[i]);
    pc = (sz == 0) ? 0 : ((sz - 1 > 3) ? 3 : sz - 1);
    check("piece_valid", piece_valid, (sz > 0) ? 1 : 0);
    check("piece", piece, (sz > 0) ? q[0] : 0);
    check("preview", preview, pv);
    check("preview_count", preview_count, pc);
    check("fill_level", fill_level, sz);
    check("bag_error", bag_error, m_err);
    check("bag_newbag", bag_newbag, exp_nb);
    check("fill_le_depth", (fill_level <= DEPTH) ? 1 : 0, 1);
  endtask

  task automatic drive_gen();
    if (exp_nb) begin
      g_on    = 1'b1;
      g_stale = $urandom_range(0, 3);
      g_low   = $urandom_range(1, 4);
      g_next  = (forced.size() > 0) ? forced.pop_front() : rand_bag();
    end else if (g_on) begin
      if (g_stale > 0) begin
        g_stale--;
      end else if (g_stuck || g_low > 0) begin
        bag_ready  = 1'b0;
        bag_pieces = 21'($urandom);
        if (g_low > 0) g_low--;
      end else begin
        bag_ready  = 1'b1;
        bag_pieces = g_next;
      end
    end
  endtask

  task automatic model_edge(input bit pop, input bit fl, input bit rst);
    int  sz = q.size();
    bit  nb = 1'b0;
    if (rst || fl) begin
      q.delete();
      pend.delete();
      m_err  = 1'b0;
      m_wait = 1'b0;
    end else begin
      if (pop && sz > 0)
        void'(q.pop_front());
      if (exp_nb) begin
        m_wait = 1'b1;
        m_low  = 1'b0;
        m_wcnt = 0;
      end else if (m_wait) begin
        if (m_low && bag_ready) begin
          m_wait = 1'b0;
          for (int k = 0; k < 7; k++)
            pend.push_back(int'((bag_pieces >> (3 * k)) & 21'd7));
        end else begin
          if (!bag_ready) m_low = 1'b1;
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_err  = 1'b1;
            m_wait = 1'b0;
          end
        end
      end else if (pend.size() > 0) begin
        int p = pend.pop_front();
        if (p != 7 && sz < DEPTH)
          q.push_back(p);
      end else if (sz <= REFILL && !m_err) begin
        nb = 1'b1;
      end
    end
    exp_nb = nb;
  endtask

  task automatic step(input bit pop, input bit fl, input bit rst);
    @(negedge clk);
    compare();
    drive_gen();
    piece_pop = pop;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    model_edge(pop, fl, rst);
  endtask

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    piece_pop  = 1'b0;
    bag_ready  = 1'b0;
    bag_pieces = '0;
    m_err      = 1'b0;
    m_wait     = 1'b0;
    m_low      = 1'b0;
    m_wcnt     = 0;
    exp_nb     = 1'b0;
    g_on       = 1'b0;
    g_stuck    = 1'b0;
    g_stale    = 0;
    g_low      = 0;
    g_next     = '0;
    forced.push_back(21'h0A7C58);
    forced.push_back({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    #2 reset = 1'b1;

    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 60; i++)
      step(0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit pop = ($urandom_range(0, 9) < 4);
      bit fl  = ($urandom_range(0, 199) == 0);
      step(pop, fl, (i == 700));
    end
    for (int i = 0; i < 200; i++)
      step(1, 0, 0);

    g_stuck = 1'b1;
    for (int i = 0; i < 3000 && !m_err; i++)
      step($urandom_range(0, 1) == 1, 0, 0);
    @(negedge clk);
    check("timeout_bag_error", bag_error, 1);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1) == 1, 0, 0);
    g_stuck = 1'b0;
    step(0, 1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 5, 0, 0);
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
